// File: rtl/trng_reader_pkg.sv
// trng_reader_pkg: shared definitions for the TRNG reader.
//   - bus register offsets (DATA, STATUS, CTRL, reserved)
//   - STATUS / CTRL bit positions
//   - collector FSM state enum
//   - byte-index and word-count widths
//   - pack_status(): assembles the STATUS register image
package trng_reader_pkg;

    localparam int unsigned BYTE_IDX_W = 2;
    localparam int unsigned COUNT_W    = 5;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int unsigned STAT_NOT_EMPTY = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_COUNT_LSB = 2;
    localparam int unsigned STAT_FAIL      = 7;
    localparam int unsigned STAT_IDX_LSB   = 8;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_FLUSH  = 1;

    typedef enum logic {
        COL_WAIT = 1'b0,
        COL_CLR  = 1'b1
    } col_state_t;

    function automatic logic [31:0] pack_status(
        input logic                  not_empty,
        input logic                  full,
        input logic [COUNT_W-1:0]    count,
        input logic                  fail,
        input logic [BYTE_IDX_W-1:0] byte_idx
    );
        logic [31:0] s;
        s = '0;
        s[STAT_NOT_EMPTY]                           = not_empty;
        s[STAT_FULL]                                = full;
        s[STAT_COUNT_LSB +: COUNT_W]                = count;
        s[STAT_FAIL]                                = fail;
        s[STAT_IDX_LSB +: BYTE_IDX_W]               = byte_idx;
        return s;
    endfunction

endpackage

// File: rtl/trng_fifo.sv
// trng_fifo: synchronous word FIFO for collected entropy.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, wdata       write a word (ignored when full unless popping too)
//   pop               remove head word (ignored when empty)
//   flush             empty the FIFO (wins over push/pop)
//   rdata             current head word (combinational)
//   count, full, empty occupancy status
module trng_fifo
    import trng_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == COUNT_W'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        // A push into a full FIFO is accepted only when a pop frees the slot
        do_push = push && (!full || do_pop);
        rdata   = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + COUNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - COUNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/trng_reader.sv
// trng_reader: collects bytes from an entropy generator, packs them
// little-endian into 32-bit words and buffers them in a FIFO readable
// over a simple register bus.
// Optional feature: define TRNG_HEALTH_EN to enable the repetition-count
// health test (sticky fail after REP_LIMIT identical consecutive bytes).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   trng_out, trng_rdy  generator byte and its level-held ready flag
//   trng_en             generator enable (CTRL.enable)
//   trng_clr            one-cycle pulse clearing the generator byte counter
//   sel, we, addr       bus strobe, write flag, register select
//   wdata               bus write data
//   rdata, rvalid       registered read data and its one-cycle qualifier
module trng_reader
    import trng_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned REP_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  trng_out,
    input  logic        trng_rdy,
    output logic        trng_en,
    output logic        trng_clr,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid
);

    col_state_t            state;
    col_state_t            state_next;
    logic                  enable;
    logic [BYTE_IDX_W-1:0] byte_idx;
    logic [23:0]           partial;
    logic                  fail;
    logic                  trip;

    logic                  rd_req;
    logic                  wr_req;
    logic                  ctrl_wr;
    logic                  flush;
    logic                  data_rd;
    logic                  pop_eff;
    logic                  can_store;
    logic                  capture;
    logic                  store_byte;
    logic                  push;
    logic [31:0]           read_mux;

    logic [31:0]           fifo_head;
    logic [COUNT_W-1:0]    fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    trng_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (data_rd),
        .flush (flush),
        .wdata ({trng_out, partial}),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign trng_en = enable;

    always_comb begin
        rd_req  = sel && !we;
        wr_req  = sel && we;
        ctrl_wr = wr_req && (addr == ADDR_CTRL);
        flush   = ctrl_wr && wdata[CTRL_FLUSH];
        data_rd = rd_req && (addr == ADDR_DATA);
        pop_eff = data_rd && !fifo_empty;
        // Only a word-completing byte needs FIFO space; a pop on the same
        // edge frees it. Discarded bytes (health fail) never need space.
        can_store = fail || !((&byte_idx) && fifo_full && !pop_eff);
    end

    // Collector FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COL_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        trng_clr   = 1'b0;
        case (state)
            COL_WAIT: begin
                if (enable && trng_rdy && can_store && !flush) begin
                    capture    = 1'b1;
                    state_next = COL_CLR;
                end
            end
            COL_CLR: begin
                trng_clr   = 1'b1;
                state_next = COL_WAIT;
            end
            default: state_next = COL_WAIT;
        endcase
    end

    always_comb begin
        store_byte = capture && !fail && !trip;
        push       = store_byte && (&byte_idx);
    end

`ifdef TRNG_HEALTH_EN
    localparam int unsigned REP_W = $clog2(REP_LIMIT + 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_next;
    logic [7:0]       prev_byte;

    always_comb begin
        rep_next = REP_W'(1);
        if ((rep_cnt != '0) && (trng_out == prev_byte)) begin
            rep_next = (rep_cnt >= REP_W'(REP_LIMIT)) ? rep_cnt : rep_cnt + REP_W'(1);
        end
        // The byte that trips the test is itself discarded
        trip = capture && (rep_next >= REP_W'(REP_LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt   <= '0;
            prev_byte <= '0;
            fail      <= 1'b0;
        end else if (flush) begin
            rep_cnt   <= '0;
            prev_byte <= '0;
            fail      <= 1'b0;
        end else if (capture) begin
            rep_cnt   <= rep_next;
            prev_byte <= trng_out;
            if (trip) begin
                fail <= 1'b1;
            end
        end
    end
`else
    assign fail = 1'b0;
    assign trip = 1'b0;
`endif

    // Byte packing and control register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable   <= 1'b0;
            byte_idx <= '0;
            partial  <= '0;
        end else begin
            if (ctrl_wr) begin
                enable <= wdata[CTRL_ENABLE];
            end
            if (flush) begin
                byte_idx <= '0;
                partial  <= '0;
            end else if (store_byte) begin
                case (byte_idx)
                    2'd0: partial[7:0]   <= trng_out;
                    2'd1: partial[15:8]  <= trng_out;
                    2'd2: partial[23:16] <= trng_out;
                    default: partial     <= '0;
                endcase
                byte_idx <= byte_idx + BYTE_IDX_W'(1);
            end
        end
    end

    // Register read port
    always_comb begin
        read_mux = '0;
        case (addr)
            ADDR_DATA:   read_mux = fifo_empty ? '0 : fifo_head;
            ADDR_STATUS: read_mux = pack_status(!fifo_empty, fifo_full, fifo_count, fail, byte_idx);
            ADDR_CTRL:   read_mux[CTRL_ENABLE] = enable;
            default:     read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_req;
            if (rd_req) begin
                rdata <= read_mux;
            end
        end
    end

endmodule

// File: tb/tb_trng_reader.sv
module tb_trng_reader;
    import trng_reader_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  trng_out;
    logic        trng_rdy;
    logic        trng_en;
    logic        trng_clr;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: words expected from the FIFO, plus the partial-word model
    logic [31:0] model_q[$];
    logic [1:0]  m_idx;
    logic        m_fail;
    logic [7:0]  last_byte;

    trng_reader #(
        .FIFO_DEPTH (DEPTH),
        .REP_LIMIT  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trng_out (trng_out),
        .trng_rdy (trng_rdy),
        .trng_en  (trng_en),
        .trng_clr (trng_clr),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid)
    );

    always #5 clk = ~clk;

    logic [23:0] m_part;

    task automatic model_store(input logic [7:0] b);
        case (m_idx)
            2'd0: m_part[7:0]   = b;
            2'd1: m_part[15:8]  = b;
            2'd2: m_part[23:16] = b;
            default: begin
                model_q.push_back({b, m_part});
                m_part = '0;
            end
        endcase
        m_idx = m_idx + 2'd1;
    endtask

    task automatic model_clear(input bit words);
        if (words) model_q.delete();
        m_idx = 2'd0;
        m_part = '0;
        m_fail = 1'b0;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int          n;
        n = model_q.size();
        s = '0;
        s[0] = (n != 0);
        s[1] = (n == DEPTH);
        s[6:2] = 5'(n);
        s[7] = m_fail;
        s[9:8] = m_idx;
        return s;
    endfunction

    function automatic logic [7:0] next_byte();
        logic [7:0] b;
        b = 8'($urandom());
        if (b == last_byte) b = b ^ 8'h01;
        last_byte = b;
        return b;
    endfunction

    // All bus/feed tasks are entered and return just after a falling edge
    task automatic do_read(input logic [1:0] a, output logic [31:0] d, output logic v);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic wait_clr(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (trng_clr) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic feed_byte(input logic [7:0] b, output bit seen, output int width);
        trng_out = b;
        trng_rdy = 1'b1;
        wait_clr(seen);
        trng_rdy = 1'b0;
        width = 0;
        if (seen) begin
            width = 1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (trng_clr) width++;
                else break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        n_cmp++; if (trng_en !== 1'b0) begin n_bad++; $display("FAIL reset_trng_en got %b want 0", trng_en); end
        n_cmp++; if (trng_clr !== 1'b0) begin n_bad++; $display("FAIL reset_trng_clr got %b want 0", trng_clr); end
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (v !== 1'b1 || d !== exp_status()) begin n_bad++; $display("FAIL reset_status got %h/%b want %h/1", d, v, exp_status()); end
        do_read(ADDR_CTRL, d, v);
        n_cmp++; if (v !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl got %h/%b want 0/1", d, v); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [31:0] exp;
        logic        v;
        bit          seen;
        int          width;
        int          pulses;
        logic [7:0]  bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        do_write(ADDR_CTRL, 32'h1);
        n_cmp++; if (trng_en !== 1'b1) begin n_bad++; $display("FAIL basic_trng_en got %b want 1", trng_en); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            feed_byte(bytes[i], seen, width);
            if (seen && width == 1) pulses++;
            model_store(bytes[i]);
        end
        n_cmp++; if (pulses != 4) begin n_bad++; $display("FAIL basic_clr_pulses got %0d want 4", pulses); end
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (d !== exp_status() || d !== 32'h5) begin n_bad++; $display("FAIL basic_status got %h want 00000005", d); end
        exp = model_q.pop_front();
        do_read(ADDR_DATA, d, v);
        n_cmp++; if (v !== 1'b1 || d !== exp) begin n_bad++; $display("FAIL basic_data got %h/%b want %h/1", d, v, exp); end
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (d !== exp_status()) begin n_bad++; $display("FAIL basic_status_after got %h want %h", d, exp_status()); end
    endtask

    task automatic test_empty_read();
        logic [31:0] d;
        logic        v;
        do_read(ADDR_CTRL, d, v);
        do_read(ADDR_DATA, d, v);
        n_cmp++; if (v !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL empty_data got %h/%b want 0/1", d, v); end
        @(negedge clk);
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL empty_rvalid_drop got %b want 0", rvalid); end
        do_write(ADDR_DATA, 32'hFFFF_FFFF);
        n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL write_rvalid got %b want 0", rvalid); end
        do_write(ADDR_STATUS, 32'hFFFF_FFFF);
        do_write(ADDR_RSVD, 32'hFFFF_FFFF);
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (d !== exp_status()) begin n_bad++; $display("FAIL empty_status got %h want %h", d, exp_status()); end
        do_read(ADDR_CTRL, d, v);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL ctrl_read got %h want 1", d); end
        do_read(ADDR_RSVD, d, v);
        n_cmp++; if (v !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL rsvd_read got %h/%b want 0/1", d, v); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [31:0] exp;
        logic        v;
        bit          seen;
        int          width;
        int          clr_cnt;
        logic [7:0]  b;
        for (int i = 0; i < DEPTH * 4 + 3; i++) begin
            b = next_byte();
            feed_byte(b, seen, width);
            n_cmp++; if (!seen || width != 1) begin n_bad++; $display("FAIL fill_clr byte %0d seen %b width %0d want 1/1", i, seen, width); end
            model_store(b);
        end
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (d !== exp_status() || d[1] !== 1'b1) begin n_bad++; $display("FAIL full_status got %h want %h", d, exp_status()); end
        b = next_byte();
        trng_out = b;
        trng_rdy = 1'b1;
        clr_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (trng_clr) clr_cnt++;
        end
        n_cmp++; if (clr_cnt != 0) begin n_bad++; $display("FAIL stall_clr got %0d pulses want 0", clr_cnt); end
        exp = model_q.pop_front();
        do_read(ADDR_DATA, d, v);
        seen = trng_clr;
        n_cmp++; if (v !== 1'b1 || d !== exp) begin n_bad++; $display("FAIL stall_pop got %h/%b want %h/1", d, v, exp); end
        if (!seen) wait_clr(seen);
        trng_rdy = 1'b0;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL stall_release got no clr want clr"); end
        @(negedge clk);
        model_store(b);
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (d !== exp_status()) begin n_bad++; $display("FAIL refill_status got %h want %h", d, exp_status()); end
        for (int i = 0; i < DEPTH; i++) begin
            exp = model_q.pop_front();
            do_read(ADDR_DATA, d, v);
            n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL drain word %0d got %h want %h", i, d, exp); end
        end
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (d !== exp_status()) begin n_bad++; $display("FAIL drained_status got %h want %h", d, exp_status()); end
    endtask

    task automatic test_health();
        logic [31:0] d;
        logic [31:0] exp;
        logic        v;
        bit          seen;
        int          width;
        do_write(ADDR_CTRL, 32'h3);
        model_clear(1'b1);
        for (int i = 0; i < 4; i++) begin
            feed_byte(8'hAA, seen, width);
            n_cmp++; if (!seen || width != 1) begin n_bad++; $display("FAIL health_clr %0d seen %b width %0d want 1/1", i, seen, width); end
`ifdef TRNG_HEALTH_EN
            if (i < 3) model_store(8'hAA);
            else m_fail = 1'b1;
`else
            model_store(8'hAA);
`endif
        end
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (d !== exp_status()) begin n_bad++; $display("FAIL health_status got %h want %h", d, exp_status()); end
`ifdef TRNG_HEALTH_EN
        feed_byte(8'h55, seen, width);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL health_discard_clr got none want pulse"); end
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (d !== 32'h380) begin n_bad++; $display("FAIL health_sticky got %h want 00000380", d); end
`else
        exp = model_q.pop_front();
        do_read(ADDR_DATA, d, v);
        n_cmp++; if (d !== exp) begin n_bad++; $display("FAIL health_off_data got %h want %h", d, exp); end
`endif
        do_write(ADDR_CTRL, 32'h3);
        model_clear(1'b1);
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL flush_status got %h want 0", d); end
    endtask

    task automatic test_disable_mid();
        logic [31:0] d;
        logic [31:0] exp;
        logic        v;
        bit          seen;
        int          width;
        int          clr_cnt;
        feed_byte(8'h01, seen, width); model_store(8'h01);
        feed_byte(8'h02, seen, width); model_store(8'h02);
        trng_out = 8'h03;
        trng_rdy = 1'b1;
        wait_clr(seen);
        trng_rdy = 1'b0;
        model_store(8'h03);
        do_write(ADDR_CTRL, 32'h0);
        n_cmp++; if (!seen || trng_clr !== 1'b0 || trng_en !== 1'b0) begin n_bad++; $display("FAIL disable_in_clr seen %b clr %b en %b want 1/0/0", seen, trng_clr, trng_en); end
        trng_out = 8'h04;
        trng_rdy = 1'b1;
        clr_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (trng_clr) clr_cnt++;
        end
        n_cmp++; if (clr_cnt != 0) begin n_bad++; $display("FAIL disabled_clr got %0d want 0", clr_cnt); end
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (d !== exp_status() || d !== 32'h300) begin n_bad++; $display("FAIL disabled_status got %h want 00000300", d); end
        do_write(ADDR_CTRL, 32'h1);
        wait_clr(seen);
        trng_rdy = 1'b0;
        @(negedge clk);
        model_store(8'h04);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL reenable_clr got none want pulse"); end
        exp = model_q.pop_front();
        do_read(ADDR_DATA, d, v);
        n_cmp++; if (d !== exp || d !== 32'h04030201) begin n_bad++; $display("FAIL resume_data got %h want 04030201", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        v;
        bit          seen;
        int          width;
        do_read(ADDR_CTRL, d, v);
        feed_byte(8'h21, seen, width); model_store(8'h21);
        feed_byte(8'h22, seen, width); model_store(8'h22);
        trng_out = 8'h23;
        trng_rdy = 1'b1;
        wait_clr(seen);
        n_cmp++; if (!seen || rdata !== 32'h1) begin n_bad++; $display("FAIL pre_reset seen %b rdata %h want 1/00000001", seen, rdata); end
        rst = 1'b1;
        #1;
        n_cmp++; if (trng_clr !== 1'b0 || trng_en !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
            n_bad++; $display("FAIL async_reset clr %b en %b rvalid %b rdata %h want all 0", trng_clr, trng_en, rvalid, rdata);
        end
        trng_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear(1'b1);
        do_read(ADDR_STATUS, d, v);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL post_reset_status got %h want 0", d); end
        do_read(ADDR_CTRL, d, v);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL post_reset_ctrl got %h want 0", d); end
    endtask

    initial begin
        rst = 1'b1;
        trng_out = '0;
        trng_rdy = 1'b0;
        sel = 1'b0;
        we = 1'b0;
        addr = '0;
        wdata = '0;
        last_byte = '0;
        model_clear(1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_empty_read();
        test_backpressure();
        test_health();
        test_disable_mid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
